// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-state encodings, jump-select codes and flag bit indices
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_ALU    = 3'b011,
    ST_LOAD   = 3'b100,
    ST_STORE  = 3'b101,
    ST_CMP    = 3'b110,
    ST_JUMP   = 3'b111
  } state_t;
  typedef enum logic [2:0] {
    JS_JMP = 3'b000,
    JS_Z   = 3'b001,
    JS_NZ  = 3'b010,
    JS_C   = 3'b011,
    JS_NC  = 3'b100,
    JS_N   = 3'b101,
    JS_NN  = 3'b110,
    JS_INC = 3'b111
  } jump_sel_t;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
endpackage

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: next-PC mux selecting branch target or wrapping PC+1 from registered flags
module pc_branch_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int FLAG_WIDTH = 3
) (
  input  logic [2:0]            jump_select,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [PC_WIDTH-1:0]   target,
  input  logic [FLAG_WIDTH-1:0] flags,
  output logic [PC_WIDTH-1:0]   pc_next
);
  logic take;
  always_comb begin
    take = (jump_select == JS_JMP) ? 1'b1 :
           (jump_select == JS_Z)   ?  flags[FLAG_Z] :
           (jump_select == JS_NZ)  ? !flags[FLAG_Z] :
           (jump_select == JS_C)   ?  flags[FLAG_C] :
           (jump_select == JS_NC)  ? !flags[FLAG_C] :
           (jump_select == JS_N)   ?  flags[FLAG_N] :
           (jump_select == JS_NN)  ? !flags[FLAG_N] : 1'b0;
    pc_next = take ? target : pc + PC_WIDTH'(1);
  end
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: control state, IR, PC and flag registers; CTRL_SEQ_IMEM_HANDSHAKE_EN adds fetch wait handshake
module controller_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int FLAG_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             next_state,
  input  logic                   enable_registers,
  input  logic                   ir_load,
  input  logic                   pc_load,
  input  logic                   flag_load,
  input  logic [2:0]             jump_select,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [FLAG_WIDTH-1:0]  alu_flags,
  output logic [2:0]             state,
  output logic [3:0]             opcode,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]    pc_addr,
  output logic [FLAG_WIDTH-1:0]  flags
`ifdef CTRL_SEQ_IMEM_HANDSHAKE_EN
  ,
  output logic                   instr_req,
  input  logic                   instr_valid
`endif
);
  logic stall;
  logic [PC_WIDTH-1:0] pc_next;
`ifdef CTRL_SEQ_IMEM_HANDSHAKE_EN
  assign instr_req = state == ST_FETCH;
  assign stall = instr_req && !instr_valid;
`else
  assign stall = 1'b0;
`endif
  assign opcode = ir[INSTR_WIDTH-1 -: 4];
  pc_branch_unit #(.PC_WIDTH(PC_WIDTH), .FLAG_WIDTH(FLAG_WIDTH)) u_branch (
    .jump_select(jump_select),
    .pc(pc_addr),
    .target(ir[PC_WIDTH-1:0]),
    .flags(flags),
    .pc_next(pc_next)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ir      <= '0;
      pc_addr <= '0;
      flags   <= '0;
    end else begin
      if (!stall) state <= next_state;
      if (enable_registers && ir_load && !stall) ir <= instr_in;
      if (enable_registers && pc_load && !stall) pc_addr <= pc_next;
      if (enable_registers && flag_load) flags <= alu_flags;
    end
  end
endmodule
